uart_cmd_rcv: RTL and testbench
===============================

UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 5208, gives clk cycles per UART bit period (50 MHz / 9600 baud).
REQ-002 Parameter TIMEOUT_CLKS, default 1_000_000, gives the inter-byte timeout in clk cycles; it is used only when CMD_TIMEOUT_EN is defined.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RX  input  1  asynchronous UART serial line; idle high; 8N1 format, LSB first.
REQ-006 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-007 cmd  output  16  assembled command, {first byte, second byte}.
REQ-008 cmd_rdy  output  1  high while cmd holds a complete, unacknowledged command.
REQ-009 frm_err  output  1  one-clk pulse when a received byte has stop bit == 0.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer before any use; both flops reset to 1.
REQ-011 Receiver FSM states SHALL be IDLE, START, DATA and STOP.
REQ-012 IDLE SHALL move to START when synchronized RX is low.
REQ-013 START SHALL wait BAUD_DIV/2 clks, then re-sample RX: low moves to DATA; high returns to IDLE as a glitch, with no byte and no error.
REQ-014 DATA SHALL sample 8 bits, one every BAUD_DIV clks at mid-bit, shifting LSB first.
REQ-015 STOP SHALL sample once, BAUD_DIV clks after the last data bit, and then return to IDLE.
REQ-016 Stop bit == 1 SHALL produce an internal byte_done strobe for 1 clk.
REQ-017 Stop bit == 0 SHALL pulse frm_err for 1 clk and discard the byte.
REQ-018 The baud counter SHALL reload on every state entry; the bit counter SHALL count 0..8 and wrap to 0 on STOP.
REQ-019 Assembler FSM states SHALL be WAIT_HI and WAIT_LO; reset state is WAIT_HI.
REQ-020 byte_done in WAIT_HI SHALL latch the byte into hi_byte and move to WAIT_LO.
REQ-021 byte_done in WAIT_LO SHALL load cmd <= {hi_byte, byte}, set cmd_rdy, and return to WAIT_HI.
REQ-022 cmd and cmd_rdy SHALL update on the clk edge after the low byte's stop-bit sample (latency 1 clk).
REQ-023 cmd SHALL change only when a low byte completes; it holds otherwise, including across clr_cmd_rdy.
REQ-024 cmd_rdy SHALL clear on clr_cmd_rdy or when a new high byte completes (byte_done in WAIT_HI).
REQ-025 When set and clear of cmd_rdy occur in the same clk, set SHALL win.
REQ-026 A new command completing while cmd_rdy=1 SHALL overwrite cmd; cmd_rdy stays high and no error is flagged.
REQ-027 frm_err in WAIT_LO SHALL discard hi_byte and return to WAIT_HI.
REQ-028 frm_err in WAIT_HI SHALL leave the assembler state unchanged.
REQ-029 clr_cmd_rdy while cmd_rdy=0 SHALL have no effect.

Reset
REQ-030 rst_n low SHALL asynchronously force: receiver IDLE, assembler WAIT_HI, cmd=16'h0000, cmd_rdy=0, frm_err=0, hi_byte=0, all counters 0.
REQ-031 Reset asserted mid-byte or mid-command SHALL abandon the partial data; after release, reception SHALL resume at the next start bit.

Configuration
REQ-032 With CMD_TIMEOUT_EN defined, a counter SHALL run while in WAIT_LO and the receiver is in IDLE.
REQ-033 With CMD_TIMEOUT_EN defined, reaching TIMEOUT_CLKS SHALL discard hi_byte and return to WAIT_HI, with no output change and no frm_err.
REQ-034 With CMD_TIMEOUT_EN defined, the counter SHALL clear on entry to WAIT_LO and on any start bit.
REQ-035 With CMD_TIMEOUT_EN undefined, no timeout logic SHALL exist, and WAIT_LO SHALL wait indefinitely.

Verification (BAUD_DIV=16, TIMEOUT_CLKS=400)
REQ-036 Send bytes 8'hA5 then 8'h3C -> cmd=16'hA53C and cmd_rdy=1 one clk after the second stop sample; frm_err never pulses.
REQ-037 With cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next clk, cmd stays 16'hA53C; then send 8'h12, 8'h34 -> cmd=16'h1234.
REQ-038 Send 8'hFF with stop bit forced 0, then 8'h56, 8'h78 -> frm_err one 1-clk pulse; cmd=16'h5678.
REQ-039 Send 8'h11, then 8'h22 with stop bit 0, then 8'h33, 8'h44 -> one frm_err pulse; cmd=16'h3344 (8'h11 discarded).
REQ-040 Drive RX low for 4 clks only -> no byte, no frm_err, FSM returns to IDLE; assert rst_n low during the 5th data bit of the next byte -> all outputs 0 and a following full command assembles correctly.
REQ-041 With CMD_TIMEOUT_EN: send 8'hAA, idle 500 clks, send 8'hBB, 8'hCC -> cmd=16'hBBCC; without the macro, the same stimulus -> cmd=16'hAABB.

Source files
------------

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver that pairs two received bytes into a 16-bit command {hi, lo}.
// Optional inter-byte timeout: define CMD_TIMEOUT_EN to drop a stale high byte after TIMEOUT_CLKS idle clocks.
module uart_cmd_rcv #(
  parameter int unsigned BAUD_DIV     = 5208,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV + 1);
  localparam logic [BAUD_W-1:0] FULL_LD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LD = BAUD_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;

  rx_state_e         rx_state_q;
  asm_state_e        asm_q;
  logic              rx_meta_q;
  logic              rx_sync_q;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              byte_done_q;
  logic              frm_err_q;
  logic [7:0]        hi_byte_q;
  logic [15:0]       cmd_q;
  logic              cmd_rdy_q;

  // Two-flop synchronizer; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver: down-counter reloads on each state entry, sample when it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frm_err_q   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            baud_cnt_q <= HALF_LD;
          end
        end
        RX_START: begin
          if (baud_cnt_q == '0) begin
            if (!rx_sync_q) begin
              rx_state_q <= RX_DATA;
              baud_cnt_q <= FULL_LD;
              bit_cnt_q  <= '0;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt_q == '0) begin
            shift_q    <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            baud_cnt_q <= FULL_LD;
            if (bit_cnt_q == 4'd7) rx_state_q <= RX_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt_q == '0) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            if (rx_sync_q) byte_done_q <= 1'b1;
            else           frm_err_q   <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            start_bit_c;
  logic            timeout_c;

  assign start_bit_c = (rx_state_q == RX_IDLE) && !rx_sync_q;
  assign timeout_c   = (asm_q == WAIT_LO) && (rx_state_q == RX_IDLE) &&
                       (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

  // Idle time spent holding a high byte; any start bit restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if ((byte_done_q && (asm_q == WAIT_HI)) || start_bit_c || timeout_c) begin
      to_cnt_q <= '0;
    end else if ((asm_q == WAIT_LO) && (rx_state_q == RX_IDLE)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`endif

  // Assembler: a new byte always beats a same-cycle clear of cmd_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HI;
      hi_byte_q <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      if (byte_done_q) begin
        if (asm_q == WAIT_HI) begin
          hi_byte_q <= shift_q;
          cmd_rdy_q <= 1'b0;
          asm_q     <= WAIT_LO;
        end else begin
          cmd_q     <= {hi_byte_q, shift_q};
          cmd_rdy_q <= 1'b1;
          asm_q     <= WAIT_HI;
        end
      end else if (frm_err_q && (asm_q == WAIT_LO)) begin
        hi_byte_q <= '0;
        asm_q     <= WAIT_HI;
      end
`ifdef CMD_TIMEOUT_EN
      else if (timeout_c) begin
        hi_byte_q <= '0;
        asm_q     <= WAIT_HI;
      end
`endif
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv at BAUD_DIV=16, TIMEOUT_CLKS=400; honours CMD_TIMEOUT_EN if defined.
module tb_uart_cmd_rcv;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  int frm_cnt   = 0;
  int frm_wide  = 0;
  logic frm_prev = 1'b0;
  logic rdy_prev = 1'b0;
  logic [7:0] pd;

  uart_cmd_rcv #(.BAUD_DIV(16), .TIMEOUT_CLKS(400)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Track frm_err pulses and the cycle cmd_rdy rises, sampled mid-cycle.
  always @(negedge clk) begin
    if (frm_err) begin
      frm_cnt++;
      if (frm_prev) frm_wide++;
    end
    frm_prev = frm_err;
    if (cmd_rdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = cmd_rdy;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame, 16 clks per bit; returns 5 clks after the stop-bit sample.
  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    @(posedge clk); #1;
    start_cyc = cyc;
    RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk);
      #1 RX = d[i];
    end
    repeat (16) @(posedge clk);
    #1 RX = stop_b;
    repeat (16) @(posedge clk);
    #1 RX = 1'b1;
  endtask

  initial begin
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", 16'(cmd_rdy), 16'h0000);
    chk("rst_frm", 16'(frm_err), 16'h0000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    send_byte(8'hA5, 1'b1);
    chk("a5_rdy_low", 16'(cmd_rdy), 16'h0000);
    send_byte(8'h3C, 1'b1);
    chk("a53c_cmd", cmd, 16'hA53C);
    chk("a53c_rdy", 16'(cmd_rdy), 16'h0001);
    chk("a53c_latency", 16'(rise_cyc - start_cyc), 16'd156);
    chk("a53c_no_frm", 16'(frm_cnt), 16'd0);

    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    chk("clr_rdy", 16'(cmd_rdy), 16'h0000);
    chk("clr_cmd_hold", cmd, 16'hA53C);
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    chk("clr_idle_rdy", 16'(cmd_rdy), 16'h0000);
    chk("clr_idle_cmd", cmd, 16'hA53C);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("1234_cmd", cmd, 16'h1234);
    chk("1234_rdy", 16'(cmd_rdy), 16'h0001);

    send_byte(8'hFF, 1'b0);
    chk("ff_frm_cnt", 16'(frm_cnt), 16'd1);
    chk("ff_rdy_kept", 16'(cmd_rdy), 16'h0001);
    chk("ff_cmd_kept", cmd, 16'h1234);
    send_byte(8'h56, 1'b1);
    chk("56_rdy_clr", 16'(cmd_rdy), 16'h0000);
    send_byte(8'h78, 1'b1);
    chk("5678_cmd", cmd, 16'h5678);
    chk("5678_frm_cnt", 16'(frm_cnt), 16'd1);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    chk("22_frm_cnt", 16'(frm_cnt), 16'd2);
    chk("22_cmd_kept", cmd, 16'h5678);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("3344_cmd", cmd, 16'h3344);
    chk("3344_rdy", 16'(cmd_rdy), 16'h0001);
    chk("frm_width", 16'(frm_wide), 16'd0);

    // Clear asserted on the very edge the low byte completes.
    send_byte(8'h9A, 1'b1);
    chk("9a_rdy_clr", 16'(cmd_rdy), 16'h0000);
    fork
      send_byte(8'hBC, 1'b1);
      begin
        @(posedge clk); #2;
        while (cyc != start_cyc + 155) begin
          @(posedge clk); #1;
        end
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
      end
    join
    chk("setwins_rdy", 16'(cmd_rdy), 16'h0001);
    chk("setwins_cmd", cmd, 16'h9ABC);

    @(posedge clk); #1 RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("glitch_frm", 16'(frm_cnt), 16'd2);
    chk("glitch_cmd", cmd, 16'h9ABC);
    chk("glitch_rdy", 16'(cmd_rdy), 16'h0001);

    // Abort a frame with reset part-way through data bit 4.
    pd = 8'h5A;
    @(posedge clk); #1 RX = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (16) @(posedge clk);
      #1 RX = pd[i];
    end
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_rdy", 16'(cmd_rdy), 16'h0000);
    chk("midrst_frm", 16'(frm_err), 16'h0000);
    RX = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    chk("dead_cmd", cmd, 16'hDEAD);
    chk("dead_rdy", 16'(cmd_rdy), 16'h0001);

    send_byte(8'hAA, 1'b1);
    repeat (500) @(posedge clk);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
`ifdef CMD_TIMEOUT_EN
    chk("timeout_cmd", cmd, 16'hBBCC);
    chk("timeout_rdy", 16'(cmd_rdy), 16'h0001);
`else
    chk("notimeout_cmd", cmd, 16'hAABB);
    chk("notimeout_rdy", 16'(cmd_rdy), 16'h0000);
`endif
    chk("final_frm_cnt", 16'(frm_cnt), 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
